// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and fills
// the IF/ID register, honouring stall, redirect/flush, end-of-ROM and fault.
module fetch_stage #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic        ifid_valid,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        done,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE);

    typedef enum logic [1:0] {RUN, DONE, FAULT} state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic        load_pc, capture, clear_valid;

    // Aligned and the whole word inside the ROM; aligned inputs cannot wrap on +3.
    function automatic logic legal(input logic [63:0] a);
        return (a[1:0] == 2'b00) && ((a + 64'd3) < MEM_BYTES);
    endfunction

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        pc_next     = pc + 64'd4;
        load_pc     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            FAULT: clear_valid = 1'b1;
            default: begin
                if (redirect) begin
                    clear_valid = 1'b1;
                    if (legal(redirect_target)) begin
                        load_pc    = 1'b1;
                        pc_next    = redirect_target;
                        state_next = RUN;
                    end else begin
                        state_next = FAULT;
                    end
                end else if (!stall) begin
                    if (state == RUN) begin
                        capture = 1'b1;
                        if (legal(pc + 64'd4)) load_pc = 1'b1;
                        else                   state_next = DONE;
                    end else begin
                        clear_valid = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            ifid_valid  <= 1'b0;
            ifid_pc     <= 64'd0;
            ifid_instr  <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            if (load_pc) pc <= pc_next;
            if (capture) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= pc;
                ifid_instr <= imem_instr;
                if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            end else if (clear_valid) begin
                ifid_valid <= 1'b0;
            end
        end
    end

    assign imem_addr = pc;
    assign done      = (state == DONE);
    assign fault     = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural ROM feeds the DUT and expected
// IF/ID captures are queued when an advance is driven, then popped after the edge.
module tb_fetch_stage;

    localparam int unsigned MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = 64'd0;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        done;
    logic        fault;
    logic [31:0] fetch_count;

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q[$];

    fetch_stage #(.MEM_SIZE(MEM_SIZE), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .done(done), .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return 32'h8B00_0000 | a[31:0];
    endfunction

    assign imem_instr = rom_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [63:0] t);
        stall = s;
        redirect = r;
        redirect_target = t;
    endtask

    // Drive an unstalled advance, expecting the word at pc_exp to be captured.
    task automatic advance(input logic [63:0] pc_exp);
        drive(1'b0, 1'b0, 64'd0);
        exp_q.push_back(pc_exp);
        cycle();
        check("cap_valid", 64'(ifid_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("cap_pc", ifid_pc, e);
            check("cap_instr", 64'(ifid_instr), 64'(rom_word(e)));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  imem_addr, 64'd0);
        check({tag, "_valid"}, 64'(ifid_valid), 64'd0);
        check({tag, "_pc"},    ifid_pc, 64'd0);
        check({tag, "_instr"}, 64'(ifid_instr), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_fault"}, 64'(fault), 64'd0);
        check({tag, "_count"}, 64'(fetch_count), 64'd0);
    endtask

    task automatic pulse_reset();
        drive(1'b0, 1'b0, 64'd0);
        #2 reset_n = 1'b0;
        #1 check_reset_values("rst");
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        #1 reset_n = 1'b0;
        #2 check_reset_values("por");
        cycle();
        reset_n = 1'b1;

        // Free run 0,4 then stall at pc=8
        advance(64'd0);
        advance(64'd4);
        check("pre_stall_addr", imem_addr, 64'd8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 64'd0);
            cycle();
            check("stall_addr", imem_addr, 64'd8);
            check("stall_pc", ifid_pc, 64'd4);
            check("stall_count", 64'(fetch_count), 64'd2);
        end
        advance(64'd8);
        advance(64'd12);
        check("run_count", 64'(fetch_count), 64'd4);

        // Redirect overrides a simultaneous stall
        drive(1'b1, 1'b1, 64'h40);
        cycle();
        check("redir_addr", imem_addr, 64'h40);
        check("redir_valid", 64'(ifid_valid), 64'd0);
        check("redir_count", 64'(fetch_count), 64'd4);
        advance(64'h40);
        check("redir_count2", 64'(fetch_count), 64'd5);

        // Misaligned redirect -> FAULT, sticky
        drive(1'b0, 1'b1, 64'h42);
        cycle();
        check("f42_fault", 64'(fault), 64'd1);
        check("f42_valid", 64'(ifid_valid), 64'd0);
        check("f42_addr", imem_addr, 64'h44);
        drive(1'b0, 1'b1, 64'h0);
        cycle();
        check("f42_sticky_fault", 64'(fault), 64'd1);
        check("f42_sticky_addr", imem_addr, 64'h44);
        drive(1'b0, 1'b0, 64'd0);
        cycle();
        check("f42_idle_count", 64'(fetch_count), 64'd5);
        check("f42_idle_done", 64'(done), 64'd0);
        pulse_reset();

        // Out-of-range redirect -> FAULT
        advance(64'd0);
        drive(1'b0, 1'b1, 64'(MEM_SIZE));
        cycle();
        check("fmem_fault", 64'(fault), 64'd1);
        check("fmem_valid", 64'(ifid_valid), 64'd0);
        check("fmem_addr", imem_addr, 64'd4);
        pulse_reset();

        // Run to end of ROM
        drive(1'b0, 1'b1, 64'(MEM_SIZE - 16));
        cycle();
        check("eor_addr", imem_addr, 64'(MEM_SIZE - 16));
        for (int i = 0; i < 4; i++) advance(64'(MEM_SIZE - 16 + 4 * i));
        check("eor_done", 64'(done), 64'd1);
        check("eor_last_addr", imem_addr, 64'(MEM_SIZE - 4));
        drive(1'b0, 1'b0, 64'd0);
        cycle();
        check("eor_idle_valid", 64'(ifid_valid), 64'd0);
        check("eor_idle_done", 64'(done), 64'd1);
        check("eor_idle_addr", imem_addr, 64'(MEM_SIZE - 4));
        check("eor_idle_count", 64'(fetch_count), 64'd4);
        drive(1'b0, 1'b1, 64'h10);
        cycle();
        check("resume_done", 64'(done), 64'd0);
        check("resume_addr", imem_addr, 64'h10);
        check("resume_valid", 64'(ifid_valid), 64'd0);
        advance(64'h10);
        check("resume_count", 64'(fetch_count), 64'd5);

        // Asynchronous reset mid-cycle while a redirect is pending
        drive(1'b0, 1'b1, 64'h80);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async");
        drive(1'b0, 1'b0, 64'd0);
        cycle();
        check("async_hold_addr", imem_addr, 64'd0);
        reset_n = 1'b1;
        advance(64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
